// File: rtl/xor_parity_engine.sv
// Framed XOR reduction unit: accumulates word XOR and count per frame and presents a
// registered result (XOR, parity, count, overflow) on a valid/ready output port.
module xor_parity_engine #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          ODD       = 1'b0,
   parameter int unsigned MAX_WORDS = 16,
   localparam int unsigned CW       = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_xor_o,
   output logic             out_parity_o,
   output logic [CW-1:0]    out_count_o,
   output logic             out_overflow_o
);

   localparam logic [CW-1:0] CntOne = CW'(1);
   localparam logic [CW-1:0] CntMax = CW'(MAX_WORDS);

   typedef enum logic {StAccum, StHold} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_xor_q, acc_xor_d;
   logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
   logic [WIDTH-1:0] res_xor_q, res_xor_d;
   logic [CW-1:0]    res_cnt_q, res_cnt_d;
   logic             res_ovf_q, res_ovf_d;

   logic [WIDTH-1:0] sum_xor;
   logic [CW-1:0]    sum_cnt;
   logic             at_max;

   assign sum_xor = acc_xor_q ^ in_data_i;
   assign sum_cnt = acc_cnt_q + CntOne;
   assign at_max  = (sum_cnt == CntMax);

   always_comb begin
      state_d   = state_q;
      acc_xor_d = acc_xor_q;
      acc_cnt_d = acc_cnt_q;
      res_xor_d = res_xor_q;
      res_cnt_d = res_cnt_q;
      res_ovf_d = res_ovf_q;
      case (state_q)
         StAccum: begin
            if (in_valid_i) begin
               if (in_last_i || at_max) begin
                  res_xor_d = sum_xor;
                  res_cnt_d = sum_cnt;
                  // An explicit last on the final allowed word is a normal close
                  res_ovf_d = !in_last_i && at_max;
                  acc_xor_d = '0;
                  acc_cnt_d = '0;
                  state_d   = StHold;
               end else begin
                  acc_xor_d = sum_xor;
                  acc_cnt_d = sum_cnt;
               end
            end
         end
         StHold: begin
            if (out_ready_i) begin
               state_d = StAccum;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StAccum;
         acc_xor_q <= '0;
         acc_cnt_q <= '0;
         res_xor_q <= '0;
         res_cnt_q <= '0;
         res_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_xor_q <= acc_xor_d;
         acc_cnt_q <= acc_cnt_d;
         res_xor_q <= res_xor_d;
         res_cnt_q <= res_cnt_d;
         res_ovf_q <= res_ovf_d;
      end
   end

   assign in_ready_o     = (state_q == StAccum);
   assign out_valid_o    = (state_q == StHold);
   assign out_xor_o      = res_xor_q;
   assign out_parity_o   = (^res_xor_q) ^ ODD;
   assign out_count_o    = res_cnt_q;
   assign out_overflow_o = res_ovf_q;

endmodule
